// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter (00-99) stepped by the rising edge of a tick
// input. A run/pause FSM gates stepping; clear, preset load, a terminal-count
// pulse and a rejected-load pulse drive the 7-segment display logic.
module bcd_updown_counter #(
    parameter bit         WRAP      = 1'b1,
    parameter logic [3:0] INIT_TENS = 4'd0,
    parameter logic [3:0] INIT_ONES = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_up,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_tc,
    output logic       o_err,
    output logic       o_running,
    output logic       o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic       tick_q;
    logic [3:0] tens_nxt, ones_nxt;
    logic       tc_nxt, err_nxt;
    logic       step, load_ok, at_max, at_min;

    // A step needs a fresh tick edge while the registered state is RUN, so a
    // tick on the edge that enters RUN is deliberately ignored.
    assign step    = i_tick & ~tick_q & (state == S_RUN);
    assign load_ok = (i_load_val[7:4] <= 4'd9) && (i_load_val[3:0] <= 4'd9);
    assign at_max  = (o_tens == 4'd9) && (o_ones == 4'd9);
    assign at_min  = (o_tens == 4'd0) && (o_ones == 4'd0);

    // Next-state, next-count and event pulses; clear beats load beats step.
    always_comb begin
        state_nxt = state;
        tens_nxt  = o_tens;
        ones_nxt  = o_ones;
        tc_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (i_clr) begin
            state_nxt = S_IDLE;
            tens_nxt  = INIT_TENS;
            ones_nxt  = INIT_ONES;
        end else if (i_load) begin
            // Load edges freeze the FSM apart from releasing DONE.
            if (load_ok) begin
                tens_nxt = i_load_val[7:4];
                ones_nxt = i_load_val[3:0];
                if (state == S_DONE) state_nxt = S_PAUSED;
            end else begin
                err_nxt = 1'b1;
            end
        end else begin
            case (state)
                S_IDLE:   if (i_run)  state_nxt = S_RUN;
                S_RUN:    if (!i_run) state_nxt = S_PAUSED;
                S_PAUSED: if (i_run)  state_nxt = S_RUN;
                default:  state_nxt = S_DONE;
            endcase
            if (step) begin
                if (i_up) begin
                    if (at_max) begin
                        tc_nxt = 1'b1;
                        if (WRAP) begin
                            tens_nxt = 4'd0;
                            ones_nxt = 4'd0;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else if (o_ones == 4'd9) begin
                        ones_nxt = 4'd0;
                        tens_nxt = o_tens + 4'd1;
                    end else begin
                        ones_nxt = o_ones + 4'd1;
                    end
                end else begin
                    if (at_min) begin
                        tc_nxt = 1'b1;
                        if (WRAP) begin
                            tens_nxt = 4'd9;
                            ones_nxt = 4'd9;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end else if (o_ones == 4'd0) begin
                        ones_nxt = 4'd9;
                        tens_nxt = o_tens - 4'd1;
                    end else begin
                        ones_nxt = o_ones - 4'd1;
                    end
                end
            end
        end
    end

    // State register, tick edge detector and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            tick_q    <= 1'b0;
            o_tens    <= INIT_TENS;
            o_ones    <= INIT_ONES;
            o_tc      <= 1'b0;
            o_err     <= 1'b0;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_q    <= i_tick;
            o_tens    <= tens_nxt;
            o_ones    <= ones_nxt;
            o_tc      <= tc_nxt;
            o_err     <= err_nxt;
            o_running <= (state_nxt == S_RUN);
            o_done    <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: one wrapping and one saturating instance share
// stimulus; an integer-count reference model predicts both every cycle.
module tb_bcd_updown_counter;

    logic       i_clk = 1'b0;
    logic       i_rst, i_tick, i_run, i_up, i_clr, i_load;
    logic [7:0] i_load_val;

    logic [3:0] tens_w, ones_w, tens_s, ones_s;
    logic       tc_w, err_w, run_w, done_w;
    logic       tc_s, err_s, run_s, done_s;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int MD_IDLE = 0, MD_RUN = 1, MD_PAUSED = 2, MD_DONE = 3;

    // index 0: wrapping instance, index 1: saturating instance
    int mcnt [2];
    int mmode[2];
    bit mtc  [2];
    bit merr [2];
    bit mtq;

    always #5 i_clk = ~i_clk;

    bcd_updown_counter #(.WRAP(1'b1), .INIT_TENS(4'd0), .INIT_ONES(4'd0)) dut_w (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_run(i_run), .i_up(i_up),
        .i_clr(i_clr), .i_load(i_load), .i_load_val(i_load_val),
        .o_tens(tens_w), .o_ones(ones_w), .o_tc(tc_w), .o_err(err_w),
        .o_running(run_w), .o_done(done_w));

    bcd_updown_counter #(.WRAP(1'b0), .INIT_TENS(4'd0), .INIT_ONES(4'd0)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_run(i_run), .i_up(i_up),
        .i_clr(i_clr), .i_load(i_load), .i_load_val(i_load_val),
        .o_tens(tens_s), .o_ones(ones_s), .o_tc(tc_s), .o_err(err_s),
        .o_running(run_s), .o_done(done_s));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: the count is a plain integer 0..99.
    task automatic model_edge();
        bit edge_ev;
        int nxt;
        edge_ev = i_tick && !mtq;
        for (int w = 0; w < 2; w++) begin
            mtc[w]  = 1'b0;
            merr[w] = 1'b0;
            if (i_rst || i_clr) begin
                mcnt[w]  = 0;
                mmode[w] = MD_IDLE;
            end else if (i_load) begin
                if (i_load_val[7:4] <= 9 && i_load_val[3:0] <= 9) begin
                    mcnt[w] = int'(i_load_val[7:4]) * 10 + int'(i_load_val[3:0]);
                    if (mmode[w] == MD_DONE) mmode[w] = MD_PAUSED;
                end else begin
                    merr[w] = 1'b1;
                end
            end else begin
                bit stepping;
                stepping = (mmode[w] == MD_RUN) && edge_ev;
                if (mmode[w] == MD_IDLE && i_run)        mmode[w] = MD_RUN;
                else if (mmode[w] == MD_RUN && !i_run)   mmode[w] = MD_PAUSED;
                else if (mmode[w] == MD_PAUSED && i_run) mmode[w] = MD_RUN;
                if (stepping) begin
                    nxt = i_up ? mcnt[w] + 1 : mcnt[w] - 1;
                    if (nxt > 99 || nxt < 0) begin
                        mtc[w] = 1'b1;
                        if (w == 0) mcnt[w] = (nxt + 100) % 100;
                        else        mmode[w] = MD_DONE;
                    end else begin
                        mcnt[w] = nxt;
                    end
                end
            end
        end
        mtq = i_rst ? 1'b0 : i_tick;
    endtask

    task automatic check_dut(input int w, input logic [3:0] t, input logic [3:0] o,
                             input logic tc, input logic err, input logic r, input logic d);
        string p;
        p = (w == 0) ? "wrap" : "sat";
        check({p, "_tens"},    {4'd0, t}, 8'(mcnt[w] / 10));
        check({p, "_ones"},    {4'd0, o}, 8'(mcnt[w] % 10));
        check({p, "_tc"},      {7'd0, tc}, {7'd0, mtc[w]});
        check({p, "_err"},     {7'd0, err}, {7'd0, merr[w]});
        check({p, "_running"}, {7'd0, r}, {7'd0, (mmode[w] == MD_RUN)});
        check({p, "_done"},    {7'd0, d}, {7'd0, (mmode[w] == MD_DONE)});
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            model_edge();
            #1;
            check_dut(0, tens_w, ones_w, tc_w, err_w, run_w, done_w);
            check_dut(1, tens_s, ones_s, tc_s, err_s, run_s, done_s);
        end
    endtask

    task automatic pulse_tick();
        i_tick = 1'b1; cyc(1);
        i_tick = 1'b0; cyc(1);
    endtask

    task automatic do_load(input logic [7:0] v);
        i_load = 1'b1; i_load_val = v; cyc(1);
        i_load = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_tick = 1'b0; i_run = 1'b0; i_up = 1'b1;
        i_clr = 1'b0; i_load = 1'b0; i_load_val = 8'h00;
        for (int w = 0; w < 2; w++) begin
            mcnt[w] = 0; mmode[w] = MD_IDLE; mtc[w] = 0; merr[w] = 0;
        end
        mtq = 1'b0;
        cyc(2);
        check("reset_count", {tens_w, ones_w}, 8'h00);
        check("reset_running", {7'd0, run_w}, 8'h00);
        i_rst = 1'b0;

        // 1: count up 00..10 with carry
        i_run = 1'b1; i_up = 1'b1; cyc(1);
        for (int k = 0; k < 10; k++) pulse_tick();
        check("t1_count", {tens_w, ones_w}, 8'h10);

        // 2: wrap up at 99 and down at 00
        do_load(8'h99);
        i_tick = 1'b1; cyc(1);
        check("t2_wrap_up", {tens_w, ones_w, 3'd0, tc_w}, 17'h00001 >> 1 << 1 | 8'h01);
        i_tick = 1'b0; cyc(1);
        check("t2_tc_once", {7'd0, tc_w}, 8'h00);
        i_up = 1'b0; pulse_tick();
        check("t2_wrap_down", {tens_w, ones_w}, 8'h99);

        // 3: saturation from 98
        i_clr = 1'b1; cyc(1); i_clr = 1'b0; cyc(1);
        i_up = 1'b1; do_load(8'h98);
        for (int k = 0; k < 3; k++) pulse_tick();
        check("t3_sat_hold", {tens_s, ones_s}, 8'h99);
        check("t3_done", {7'd0, done_s}, 8'h01);
        pulse_tick();
        i_clr = 1'b1; cyc(1); i_clr = 1'b0;
        check("t3_clr", {tens_s, ones_s, 3'd0, done_s}, 8'h00);

        // 4: held tick = one step; paused ignores ticks
        cyc(1);
        i_tick = 1'b1; cyc(5); i_tick = 1'b0; cyc(1);
        check("t4_held", {tens_w, ones_w}, 8'h01);
        i_run = 1'b0; cyc(1);
        pulse_tick();
        check("t4_paused", {tens_w, ones_w}, 8'h01);

        // 5: rejected load, then clear beats tick
        do_load(8'h9A);
        check("t5_err", {7'd0, err_w}, 8'h01);
        cyc(1);
        i_run = 1'b1; cyc(1);
        i_clr = 1'b1; i_tick = 1'b1; cyc(1);
        i_clr = 1'b0; i_tick = 1'b0;
        check("t5_clr_tick", {tens_w, ones_w}, 8'h00);

        // 6: reset mid-run
        cyc(1);
        do_load(8'h50);
        for (int k = 0; k < 7; k++) pulse_tick();
        check("t6_57", {tens_w, ones_w}, 8'h57);
        i_rst = 1'b1; cyc(1); i_rst = 1'b0; i_run = 1'b0;
        pulse_tick(); pulse_tick();
        check("t6_rst", {tens_w, ones_w, 3'd0, run_w}, 8'h00);
        i_run = 1'b1; cyc(1); pulse_tick();
        check("t6_resume", {tens_w, ones_w}, 8'h01);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            i_rst      = ($urandom_range(0, 127) == 0);
            i_clr      = ($urandom_range(0, 63) == 0);
            i_load     = ($urandom_range(0, 31) == 0);
            i_load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                         {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0) i_run = ~i_run;
            if ($urandom_range(0, 31) == 0) i_up  = ~i_up;
            i_tick     = ($urandom_range(0, 2) == 0);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
